parking_slot_allocator: RTL and testbench
=========================================

# parking_slot_allocator

Entry/exit controller for the 8-slot car park. It turns entry requests and exit reports into the registered 8-bit slot-occupancy vector `car[7:0]`, which feeds the occupancy-count/seven-segment display block. It allocates the lowest free slot to each arriving car and drives the entry gate through a timed open/close state machine. It releases slots on exit and rolls back an allocation if the car never passes the gate.

## Interface
- `GATE_TIMEOUT`, 16: maximum cycles the gate stays open waiting for `car_pass`; legal range 1..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous reset, active-low; sampled on rising edge of `clk`.
- `entry_req` input 1: car present at entry; level, rising edge detected internally.
- `car_pass` input 1: gate sensor; car has cleared the entry gate.
- `exit_valid` input 1: one-cycle strobe, a car has left slot `exit_slot`.
- `exit_slot` input 3: slot index for `exit_valid`.
- `car` output 8: occupancy vector, bit i = slot i occupied (registered).
- `count` output 4: popcount of `car`, 0..8.
- `full` output 1: `count == 8`.
- `gate_open` output 1: gate actuator, high while in OPEN.
- `entry_ack` output 1: one-cycle pulse, slot granted.
- `entry_slot` output 3: granted slot index; valid with `entry_ack`, holds until next grant.
- `entry_reject` output 1: one-cycle pulse, request refused because the park is full.
- `entry_timeout` output 1: one-cycle pulse, grant rolled back.
- `exit_ack` output 1: one-cycle pulse, exit accepted.
- `exit_err` output 1: one-cycle pulse, exit refused.

## Operation
- Reset (`rst_n` = 0 at a clock edge): `car` = 0, `count` = 0, `full` = 0, `gate_open` = 0, all pulses = 0, `entry_slot` = 0, timer = 0, state = IDLE. The request-edge history register is cleared to 0. Reset mid-OPEN therefore closes the gate and discards the pending slot.
- Request edge: `req_rise = entry_req & ~entry_req_q`. `entry_req_q` is registered every cycle. Holding `entry_req` high produces one event only.
- FSM states: IDLE, OPEN.
  - IDLE, `req_rise`, not full:
    - pick the lowest index i with `car[i] = 0`;
    - set `car[i]`;
    - `entry_slot` ← i;
    - pulse `entry_ack`;
    - `gate_open` ← 1;
    - timer ← 0;
    - go to OPEN.
  - IDLE, `req_rise`, full: pulse `entry_reject`; stay in IDLE.
  - OPEN, `car_pass` = 1: `gate_open` ← 0; go to IDLE. The slot stays occupied.
  - OPEN, `car_pass` = 0: timer increments. When the timer reaches `GATE_TIMEOUT` − 1:
    - clear `car[entry_slot]`;
    - pulse `entry_timeout`;
    - `gate_open` ← 0;
    - go to IDLE.
  - OPEN, `req_rise`: ignored. No ack and no reject; the event is not queued.
- Exit path, evaluated in both states:
  - `exit_valid` and `car[exit_slot] = 1`, and not (state = OPEN and `exit_slot = entry_slot`): clear `car[exit_slot]`; pulse `exit_ack`.
  - Otherwise, with `exit_valid`: pulse `exit_err`; `car` is unchanged.
- Simultaneous exit and grant in the same cycle:
  - allocation searches the pre-update `car`, so a slot freed this cycle is not eligible;
  - if `full` was 1 and an exit occurs in the same cycle, the entry is rejected.
  - Both updates apply in the same cycle.
- `count` and `full` are combinational from the `car` register. They change in the same cycle as `car`.

## Timing
- Latency:
  - `req_rise` sampled at edge k: `entry_ack`/`entry_reject`, the `car` update and `gate_open` are visible after edge k+1.
  - `exit_valid` at edge k: `exit_ack`/`exit_err` and the `car` update are visible after edge k+1.
- Every pulse output is high for exactly one cycle.
- Gate hold:
  - `gate_open` is high for at most `GATE_TIMEOUT` cycles.
  - If `car_pass` is first high in OPEN cycle j (1-based), `gate_open` is high for exactly j cycles.
- Back-to-back: a new `req_rise` is accepted the first cycle after returning to IDLE.

## Test plan
- Reset, then three requests, each followed by `car_pass` on the 2nd OPEN cycle:
  - grants are slots 0, 1, 2;
  - `car` = 8'h07, `count` = 3;
  - `gate_open` is high 2 cycles per entry.
- Fill all 8 slots, then raise `entry_req`: `entry_reject` pulses once, `full` = 1, `car` = 8'hFF, `gate_open` stays 0. Holding `entry_req` high gives no further reject.
- `car` = 8'h0F, exit slot 1:
  - `exit_ack` pulses, `car` = 8'h0D;
  - the next request is granted slot 1, `car` = 8'h0F.
- Grant slot 0 and never assert `car_pass` (`GATE_TIMEOUT` = 16): `gate_open` is high for exactly 16 cycles, then `entry_timeout` pulses and `car` = 8'h00.
- Error cases:
  - exit of an empty slot 5: `exit_err` pulses, `car` unchanged;
  - exit of the slot pending in OPEN: `exit_err` pulses, slot stays set.
- Two cases:
  - `car` = 8'hFF, with `exit_valid` for slot 3 and `req_rise` in the same cycle: reject plus `exit_ack`, `car` = 8'hF7.
  - `rst_n` low during OPEN: the next cycle shows `car` = 0, `gate_open` = 0, state IDLE.

Source files
------------

// File: rtl/parking_slot_allocator.sv
// Purpose: 8-slot car park entry/exit controller: lowest-free slot grant, timed entry gate, exit release.
// Latency: every request edge or exit strobe sampled at edge k is answered (pulse + car update) after edge k+1.
// Backpressure: none; requests arriving while the gate is open are dropped, and a request arriving while the park is full is rejected.
module parking_slot_allocator #(
    parameter int GATE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       car_pass,
    input  logic       exit_valid,
    input  logic [2:0] exit_slot,
    output logic [7:0] car,
    output logic [3:0] count,
    output logic       full,
    output logic       gate_open,
    output logic       entry_ack,
    output logic [2:0] entry_slot,
    output logic       entry_reject,
    output logic       entry_timeout,
    output logic       exit_ack,
    output logic       exit_err
);

    typedef enum logic {IDLE, OPEN} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(GATE_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic [7:0] car_nxt;
    logic [2:0] entry_slot_nxt;
    logic       entry_req_q;
    logic       req_rise;
    logic       free_vld;
    logic [2:0] free_idx;
    logic       exit_ok;
    logic       entry_ack_nxt, entry_reject_nxt, entry_timeout_nxt;
    logic       exit_ack_nxt, exit_err_nxt;

    assign req_rise  = entry_req & ~entry_req_q;
    assign full      = (count == 4'd8);
    assign gate_open = (state == OPEN);

    // Occupancy count for the display block, straight from the car register.
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, car[i]};
        end
    end

    // Lowest free slot in the pre-update vector; a slot freed this cycle is not eligible.
    always_comb begin
        free_vld = 1'b0;
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!car[i]) begin
                free_vld = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

    // Exit is legal only for an occupied slot that is not the one still waiting at the gate.
    assign exit_ok = exit_valid && car[exit_slot] &&
                     !((state == OPEN) && (exit_slot == entry_slot));

    // Next-state, slot bookkeeping and pulse generation.
    always_comb begin
        state_nxt         = state;
        timer_nxt         = timer;
        car_nxt           = car;
        entry_slot_nxt    = entry_slot;
        entry_ack_nxt     = 1'b0;
        entry_reject_nxt  = 1'b0;
        entry_timeout_nxt = 1'b0;
        exit_ack_nxt      = 1'b0;
        exit_err_nxt      = 1'b0;

        if (exit_valid) begin
            if (exit_ok) begin
                car_nxt[exit_slot] = 1'b0;
                exit_ack_nxt       = 1'b1;
            end else begin
                exit_err_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (req_rise) begin
                    if (free_vld) begin
                        car_nxt[free_idx] = 1'b1;
                        entry_slot_nxt    = free_idx;
                        entry_ack_nxt     = 1'b1;
                        timer_nxt         = 8'd0;
                        state_nxt         = OPEN;
                    end else begin
                        entry_reject_nxt = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (car_pass) begin
                    state_nxt = IDLE;
                end else if (timer == TIMER_LAST) begin
                    // Car never cleared the gate: give the slot back.
                    car_nxt[entry_slot] = 1'b0;
                    entry_timeout_nxt   = 1'b1;
                    state_nxt           = IDLE;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= 8'd0;
            car           <= 8'd0;
            entry_slot    <= 3'd0;
            entry_req_q   <= 1'b0;
            entry_ack     <= 1'b0;
            entry_reject  <= 1'b0;
            entry_timeout <= 1'b0;
            exit_ack      <= 1'b0;
            exit_err      <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            car           <= car_nxt;
            entry_slot    <= entry_slot_nxt;
            entry_req_q   <= entry_req;
            entry_ack     <= entry_ack_nxt;
            entry_reject  <= entry_reject_nxt;
            entry_timeout <= entry_timeout_nxt;
            exit_ack      <= exit_ack_nxt;
            exit_err      <= exit_err_nxt;
        end
    end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Purpose: self-checking bench for parking_slot_allocator against a behavioural car-park model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives every input directly.
module tb_parking_slot_allocator;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       car_pass = 1'b0;
    logic       exit_valid = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic [7:0] car;
    logic [3:0] count;
    logic       full, gate_open, entry_ack, entry_reject, entry_timeout, exit_ack, exit_err;
    logic [2:0] entry_slot;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-slot occupancy, whether a car is waiting at the gate,
    // how many cycles the gate has been open so far, and the last granted slot.
    bit m_occ[8];
    bit m_open;
    int m_open_cycles;
    int m_slot;
    bit m_req_prev;
    bit m_ack, m_rej, m_to, m_xack, m_xerr;

    parking_slot_allocator #(.GATE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .car_pass(car_pass),
        .exit_valid(exit_valid), .exit_slot(exit_slot), .car(car), .count(count),
        .full(full), .gate_open(gate_open), .entry_ack(entry_ack), .entry_slot(entry_slot),
        .entry_reject(entry_reject), .entry_timeout(entry_timeout),
        .exit_ack(exit_ack), .exit_err(exit_err)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_occ[i]);
        return n;
    endfunction

    function automatic logic [7:0] m_car();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs as they stand at the edge.
    task automatic model_step();
        bit rise;
        bit was_full;
        bit nxt[8];
        rise = entry_req && !m_req_prev;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_occ[i] = 1'b0;
            m_open = 0; m_open_cycles = 0; m_slot = 0; m_req_prev = 0;
            m_ack = 0; m_rej = 0; m_to = 0; m_xack = 0; m_xerr = 0;
            return;
        end
        m_req_prev = entry_req;
        m_ack = 0; m_rej = 0; m_to = 0; m_xack = 0; m_xerr = 0;
        was_full = (m_count() == 8);
        nxt = m_occ;
        if (exit_valid) begin
            if (m_occ[exit_slot] && !(m_open && int'(exit_slot) == m_slot)) begin
                nxt[exit_slot] = 1'b0;
                m_xack = 1;
            end else begin
                m_xerr = 1;
            end
        end
        if (m_open) begin
            m_open_cycles++;
            if (car_pass) begin
                m_open = 0;
            end else if (m_open_cycles == TO) begin
                nxt[m_slot] = 1'b0;
                m_to = 1;
                m_open = 0;
            end
        end else if (rise) begin
            if (was_full) begin
                m_rej = 1;
            end else begin
                int pick = -1;
                for (int i = 0; i < 8; i++) if (pick < 0 && !m_occ[i]) pick = i;
                nxt[pick] = 1'b1;
                m_slot = pick;
                m_ack = 1;
                m_open = 1;
                m_open_cycles = 0;
            end
        end
        m_occ = nxt;
    endtask

    task automatic tick();
        logic [21:0] obs, exp;
        @(posedge clk);
        model_step();
        #1;
        obs = {car, count, full, gate_open, entry_ack, entry_slot,
               entry_reject, entry_timeout, exit_ack, exit_err};
        exp = {m_car(), 4'(m_count()), (m_count() == 8), m_open, m_ack, 3'(m_slot),
               m_rej, m_to, m_xack, m_xerr};
        chk("model", {10'd0, obs}, {10'd0, exp});
    endtask

    task automatic do_exit(input int s);
        exit_valid = 1'b1;
        exit_slot  = 3'(s);
        tick();
        exit_valid = 1'b0;
    endtask

    // Request entry and assert car_pass during OPEN cycle n; returns gate-open cycle count.
    task automatic enter(input int n, input int exp_slot, output int opened);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("grant_ack", {31'd0, entry_ack}, 32'd1);
        chk("grant_slot", {29'd0, entry_slot}, exp_slot);
        opened = int'(gate_open);
        repeat (n - 1) begin
            tick();
            opened += int'(gate_open);
        end
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;
    endtask

    initial begin
        int opened;
        int guard;

        // Reset
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_car", {24'd0, car}, 32'h0);
        chk("rst_gate", {31'd0, gate_open}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three entries, car_pass on the 2nd OPEN cycle
        for (int i = 0; i < 3; i++) begin
            enter(2, i, opened);
            chk("gate_cycles_2", opened, 32'd2);
        end
        chk("car_07", {24'd0, car}, 32'h07);
        chk("count_3", {28'd0, count}, 32'd3);

        // Fill the park, then a rejected request held high
        for (int i = 3; i < 8; i++) enter(1, i, opened);
        chk("car_ff", {24'd0, car}, 32'hFF);
        entry_req = 1'b1;
        tick();
        chk("reject", {31'd0, entry_reject}, 32'd1);
        chk("full", {31'd0, full}, 32'd1);
        chk("gate_closed_full", {31'd0, gate_open}, 32'd0);
        tick(); tick();
        chk("reject_once", {31'd0, entry_reject}, 32'd0);
        entry_req = 1'b0;
        tick();

        // Down to 0F, release slot 1, regrant slot 1
        for (int s = 4; s < 8; s++) do_exit(s);
        chk("car_0f", {24'd0, car}, 32'h0F);
        do_exit(1);
        chk("exit_ack", {31'd0, exit_ack}, 32'd1);
        chk("car_0d", {24'd0, car}, 32'h0D);
        enter(1, 1, opened);
        chk("car_0f_again", {24'd0, car}, 32'h0F);

        // Empty, then a grant that times out
        for (int s = 0; s < 4; s++) do_exit(s);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        opened = 0;
        guard = 0;
        while (gate_open && guard < 4 * TO) begin
            opened++;
            guard++;
            tick();
        end
        chk("timeout_gate_cycles", opened, TO);
        chk("timeout_pulse", {31'd0, entry_timeout}, 32'd1);
        chk("timeout_car", {24'd0, car}, 32'h0);

        // Exit of an empty slot, and exit of the slot pending at the gate
        do_exit(5);
        chk("err_empty", {31'd0, exit_err}, 32'd1);
        chk("err_empty_car", {24'd0, car}, 32'h0);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        do_exit(0);
        chk("err_pending", {31'd0, exit_err}, 32'd1);
        chk("err_pending_car", {31'd0, car[0]}, 32'd1);
        car_pass = 1'b1;
        tick();
        car_pass = 1'b0;

        // Full park: exit and request in the same cycle
        for (int i = 1; i < 8; i++) enter(1, i, opened);
        exit_valid = 1'b1;
        exit_slot  = 3'd3;
        entry_req  = 1'b1;
        tick();
        exit_valid = 1'b0;
        entry_req  = 1'b0;
        chk("simul_reject", {31'd0, entry_reject}, 32'd1);
        chk("simul_exit_ack", {31'd0, exit_ack}, 32'd1);
        chk("simul_car", {24'd0, car}, 32'hF7);
        tick();

        // Reset while the gate is open
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("open_before_rst", {31'd0, gate_open}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_open_car", {24'd0, car}, 32'h0);
        chk("rst_open_gate", {31'd0, gate_open}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            entry_req  = ($urandom_range(0, 2) == 0);
            car_pass   = ($urandom_range(0, 5) == 0);
            exit_valid = ($urandom_range(0, 3) == 0);
            exit_slot  = 3'($urandom_range(0, 7));
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
